i2s_tx: RTL and testbench

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/i2s_tx_if.sv | 24 ++
 rtl/i2s_tx.sv | 134 +++++++++++++
 tb/tb_i2s_tx.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_if.sv
// Stereo sample handshake into the I2S transmitter: a source presents a left/right
// pair with sample_valid_in and the transmitter accepts it while sample_ready_out is high.
interface i2s_tx_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic signed [SAMPLE_WIDTH-1:0] left_in;
  logic signed [SAMPLE_WIDTH-1:0] right_in;
  logic                           sample_valid_in;
  logic                           sample_ready_out;

  modport master (
    output left_in,
    output right_in,
    output sample_valid_in,
    input  sample_ready_out
  );

  modport slave (
    input  left_in,
    input  right_in,
    input  sample_valid_in,
    output sample_ready_out
  );
endinterface

// File: rtl/i2s_tx.sv
// I2S transmitter: divides clk_in into BCLK, frames 64 slots per stereo frame and
// serialises a one-deep buffered sample pair MSB-first, one BCLK after each LRCLK edge.
module i2s_tx #(
  parameter int DIV          = 16,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic    clk_in,
  input  logic    rst_in,
  i2s_tx_if.slave smp,
  output logic    i2s_clk,
  output logic    lrcl_clk,
  output logic    sdata_out,
  output logic    frame_start_out,
  output logic    underrun_out
);

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
  localparam logic [4:0] SW_P     = 5'(SAMPLE_WIDTH);
  localparam logic [5:0] SLOT_END = 6'd63;

  logic [7:0]              div_q, div_d;
  logic                    bclk_q, bclk_d;
  logic [5:0]              slot_q, slot_d;
  logic                    lrcl_q, lrcl_d;
  logic                    sdata_q, sdata_d;
  logic                    buf_full_q, buf_full_d;
  logic                    ready_q, ready_d;
  logic [SAMPLE_WIDTH-1:0] buf_l_q, buf_l_d;
  logic [SAMPLE_WIDTH-1:0] buf_r_q, buf_r_d;
  logic [SAMPLE_WIDTH-1:0] frm_l_q, frm_l_d;
  logic [SAMPLE_WIDTH-1:0] frm_r_q, frm_r_d;
  logic                    fs_q, fs_d;
  logic                    und_q, und_d;

  logic                    tick;
  logic                    fall;
  logic                    load;
  logic                    accept;
  logic [4:0]              pos;
  logic [SAMPLE_WIDTH-1:0] word;
  logic [SAMPLE_WIDTH-1:0] shifted;

  // Bit clock and slot counter; all serial outputs move only on the BCLK fall.
  always_comb begin
    tick   = (div_q == DIV_LAST);
    fall   = tick && bclk_q;
    load   = fall && (slot_q == SLOT_END);
    div_d  = tick ? '0 : div_q + 8'd1;
    bclk_d = tick ? ~bclk_q : bclk_q;
    slot_d = fall ? slot_q + 6'd1 : slot_q;
    lrcl_d = fall ? slot_d[5] : lrcl_q;
  end

  // Slot p carries bit (SAMPLE_WIDTH-p); the load slot (p=0) always emits 0, so the
  // frame registers being replaced on that same fall never reach the line.
  always_comb begin
    pos     = slot_d[4:0];
    word    = slot_d[5] ? frm_r_q : frm_l_q;
    shifted = word >> (SW_P - pos);
    sdata_d = sdata_q;
    if (fall) begin
      sdata_d = ((pos != 5'd0) && (pos <= SW_P)) ? shifted[0] : 1'b0;
    end
  end

  // Holding buffer and frame load; an accept on a load cycle sees the pre-edge
  // (empty) buffer, so the load takes zeros and the new pair waits a frame.
  always_comb begin
    accept     = smp.sample_valid_in && ready_q;
    buf_full_d = buf_full_q;
    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;
    frm_l_d    = frm_l_q;
    frm_r_d    = frm_r_q;
    if (load) begin
      if (buf_full_q) begin
        frm_l_d    = buf_l_q;
        frm_r_d    = buf_r_q;
        buf_full_d = 1'b0;
      end else begin
        frm_l_d = '0;
        frm_r_d = '0;
      end
    end
    if (accept) begin
      buf_l_d    = smp.left_in;
      buf_r_d    = smp.right_in;
      buf_full_d = 1'b1;
    end
    ready_d = ~buf_full_d;
    fs_d    = load;
    und_d   = load && !buf_full_q;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      div_q      <= '0;
      bclk_q     <= 1'b0;
      slot_q     <= '1;
      lrcl_q     <= 1'b0;
      sdata_q    <= 1'b0;
      buf_full_q <= 1'b0;
      ready_q    <= 1'b1;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      frm_l_q    <= '0;
      frm_r_q    <= '0;
      fs_q       <= 1'b0;
      und_q      <= 1'b0;
    end else begin
      div_q      <= div_d;
      bclk_q     <= bclk_d;
      slot_q     <= slot_d;
      lrcl_q     <= lrcl_d;
      sdata_q    <= sdata_d;
      buf_full_q <= buf_full_d;
      ready_q    <= ready_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
      frm_l_q    <= frm_l_d;
      frm_r_q    <= frm_r_d;
      fs_q       <= fs_d;
      und_q      <= und_d;
    end
  end

  assign i2s_clk              = bclk_q;
  assign lrcl_clk             = lrcl_q;
  assign sdata_out            = sdata_q;
  assign frame_start_out      = fs_q;
  assign underrun_out         = und_q;
  assign smp.sample_ready_out = ready_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: a frame-schedule model predicts loads, underruns
// and the 64-slot serial stream, which is rebuilt from sdata_out sampled on BCLK rises.
module tb_i2s_tx;
  localparam int          DIV    = 16;
  localparam int          SW     = 16;
  localparam int unsigned FRAME  = 128 * DIV;
  localparam logic [63:0] LR_EXP = 64'h0000_0000_FFFF_FFFF;

  typedef struct packed {
    logic [63:0] bits;
    logic [63:0] lr;
    logic        und;
  } obs_t;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic        und;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i2s_clk, lrcl_clk, sdata_out, frame_start_out, underrun_out;

  i2s_tx_if #(.SAMPLE_WIDTH(SW)) smp ();

  i2s_tx #(.DIV(DIV), .SAMPLE_WIDTH(SW)) dut (
    .clk_in          (clk),
    .rst_in          (rst_n),
    .smp             (smp),
    .i2s_clk         (i2s_clk),
    .lrcl_clk        (lrcl_clk),
    .sdata_out       (sdata_out),
    .frame_start_out (frame_start_out),
    .underrun_out    (underrun_out)
  );

  always #5 clk = ~clk;

  int          compared   = 0;
  int          mismatched = 0;
  int unsigned e          = 0;
  int unsigned viol       = 0;
  bit          m_full     = 0;
  bit          m_acc      = 0;
  logic [15:0] m_bl, m_br;
  exp_t        exp_q[$];
  obs_t        obs_q[$];
  bit          capt       = 0;
  int unsigned nbits      = 0;
  obs_t        cur;

  function automatic logic [63:0] stream(input logic [15:0] l, input logic [15:0] r);
    return {1'b0, l, 15'h0, 1'b0, r, 15'h0};
  endfunction

  function automatic bit load_edge(input int unsigned n);
    return (n >= 2 * DIV) && (((n - 2 * DIV) % FRAME) == 0);
  endfunction

  task automatic reset_model();
    e      = 0;
    m_full = 0;
    m_acc  = 0;
    capt   = 0;
    nbits  = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  // One clk_in cycle: advance the frame-schedule model, flag per-cycle timing
  // deviations into viol, and rebuild frames from BCLK-rise samples.
  task automatic cycle();
    logic        pb, plr, psd, v, xlr;
    logic [15:0] il, ir;
    bit          ld, xu;
    int unsigned f, b;
    pb  = i2s_clk;
    plr = lrcl_clk;
    psd = sdata_out;
    v   = smp.sample_valid_in;
    il  = smp.left_in;
    ir  = smp.right_in;
    @(posedge clk);
    e++;
    ld    = load_edge(e);
    m_acc = v && !m_full;
    xu    = ld && !m_full;
    if (ld) begin
      if (m_full) begin
        exp_q.push_back('{l: m_bl, r: m_br, und: 1'b0});
        m_full = 0;
      end else begin
        exp_q.push_back('{l: 16'h0, r: 16'h0, und: 1'b1});
      end
    end
    if (m_acc) begin
      m_bl   = il;
      m_br   = ir;
      m_full = 1;
    end
    f   = e / (2 * DIV);
    b   = (63 + f) % 64;
    xlr = (f == 0) ? 1'b0 : (b >= 32);
    #1;
    if (i2s_clk !== 1'((e / DIV) % 2)) viol++;
    if (lrcl_clk !== xlr) viol++;
    if (frame_start_out !== ld) viol++;
    if (underrun_out !== xu) viol++;
    if (smp.sample_ready_out !== !m_full) viol++;
    if (!(pb === 1'b1 && i2s_clk === 1'b0) && (lrcl_clk !== plr || sdata_out !== psd)) viol++;
    if (frame_start_out === 1'b1) begin
      capt     = 1;
      nbits    = 0;
      cur.und  = underrun_out;
      cur.bits = '0;
      cur.lr   = '0;
    end else if (capt && pb === 1'b0 && i2s_clk === 1'b1) begin
      cur.bits = {cur.bits[62:0], sdata_out};
      cur.lr   = {cur.lr[62:0], lrcl_clk};
      nbits++;
      if (nbits == 64) begin
        obs_q.push_back(cur);
        capt = 0;
      end
    end
  endtask

  task automatic run_frames(input int unsigned n);
    int unsigned budget;
    budget = (n + 2) * FRAME;
    while (obs_q.size() < n && budget > 0) begin
      cycle();
      budget--;
    end
  endtask

  task automatic test_reset();
    smp.sample_valid_in = 1'b0;
    smp.left_in         = '0;
    smp.right_in        = '0;
    rst_n               = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++; if (i2s_clk !== 1'b0) begin mismatched++; $display("FAIL reset_i2s_clk got %b want 0", i2s_clk); end
    compared++; if (lrcl_clk !== 1'b0) begin mismatched++; $display("FAIL reset_lrcl got %b want 0", lrcl_clk); end
    compared++; if (sdata_out !== 1'b0) begin mismatched++; $display("FAIL reset_sdata got %b want 0", sdata_out); end
    compared++; if (smp.sample_ready_out !== 1'b1) begin mismatched++; $display("FAIL reset_ready got %b want 1", smp.sample_ready_out); end
    compared++; if (frame_start_out !== 1'b0) begin mismatched++; $display("FAIL reset_frame_start got %b want 0", frame_start_out); end
    compared++; if (underrun_out !== 1'b0) begin mismatched++; $display("FAIL reset_underrun got %b want 0", underrun_out); end
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    viol = 0;
  endtask

  task automatic test_idle();
    obs_t o;
    exp_t x;
    run_frames(2);
    compared++; if (obs_q.size() < 2) begin mismatched++; $display("FAIL idle_timeout frames=%0d want 2", obs_q.size()); end
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      o = obs_q.pop_front();
      x = exp_q.pop_front();
      compared++;
      if (o.bits !== 64'h0 || o.und !== 1'b1 || o.lr !== LR_EXP || o.bits !== stream(x.l, x.r) || o.und !== x.und) begin
        mismatched++;
        $display("FAIL idle_frame got bits=%h und=%b lr=%h want bits=0 und=1 lr=%h", o.bits, o.und, o.lr, LR_EXP);
      end
    end
    compared++; if (viol != 0) begin mismatched++; $display("FAIL idle_timing violations=%0d want 0", viol); end
    viol = 0;
  endtask

  task automatic test_patterns();
    logic [15:0] tl[3];
    logic [15:0] tr[3];
    obs_t        o;
    exp_t        x;
    bit          found;
    tl[0] = 16'hA5C3; tr[0] = 16'h8001;
    tl[1] = 16'h7FFF; tr[1] = 16'h8000;
    tl[2] = 16'($urandom); tr[2] = 16'($urandom);
    for (int i = 0; i < 3; i++) begin
      found = 0;
      smp.left_in         = tl[i];
      smp.right_in        = tr[i];
      smp.sample_valid_in = 1'b1;
      cycle();
      smp.sample_valid_in = 1'b0;
      smp.left_in         = ~tl[i];
      smp.right_in        = ~tr[i];
      run_frames(2);
      compared++; if (obs_q.size() < 2) begin mismatched++; $display("FAIL pattern%0d_timeout frames=%0d want 2", i, obs_q.size()); end
      while (obs_q.size() != 0 && exp_q.size() != 0) begin
        o = obs_q.pop_front();
        x = exp_q.pop_front();
        if (o.bits === stream(tl[i], tr[i]) && o.und === 1'b0) found = 1;
        compared++;
        if (o.bits !== stream(x.l, x.r) || o.und !== x.und || o.lr !== LR_EXP) begin
          mismatched++;
          $display("FAIL pattern%0d_frame got bits=%h und=%b lr=%h want bits=%h und=%b lr=%h",
                   i, o.bits, o.und, o.lr, stream(x.l, x.r), x.und, LR_EXP);
        end
      end
      compared++;
      if (!found) begin
        mismatched++;
        $display("FAIL pattern%0d_serial got no frame with bits=%h und=0", i, stream(tl[i], tr[i]));
      end
    end
    compared++; if (viol != 0) begin mismatched++; $display("FAIL pattern_timing violations=%0d want 0", viol); end
    viol = 0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] base, nxt;
    int unsigned k, budget;
    obs_t        o;
    exp_t        x;
    bit          seen;
    base   = 16'($urandom);
    k      = 0;
    budget = 8 * FRAME;
    seen   = 0;
    nxt    = base;
    smp.left_in         = base;
    smp.right_in        = base ^ 16'h5A5A;
    smp.sample_valid_in = 1'b1;
    while (obs_q.size() < 5 && budget > 0) begin
      cycle();
      budget--;
      if (m_acc) begin
        k++;
        smp.left_in  = 16'(base + k);
        smp.right_in = 16'(base + k) ^ 16'h5A5A;
      end
    end
    smp.sample_valid_in = 1'b0;
    compared++; if (obs_q.size() < 5) begin mismatched++; $display("FAIL b2b_timeout frames=%0d want 5", obs_q.size()); end
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      o = obs_q.pop_front();
      x = exp_q.pop_front();
      compared++;
      if (o.bits !== stream(x.l, x.r) || o.und !== x.und || o.lr !== LR_EXP) begin
        mismatched++;
        $display("FAIL b2b_frame got bits=%h und=%b want bits=%h und=%b", o.bits, o.und, stream(x.l, x.r), x.und);
      end
      if (o.und === 1'b0) seen = 1;
      if (seen) begin
        compared++;
        if (o.und !== 1'b0 || o.bits !== stream(nxt, nxt ^ 16'h5A5A)) begin
          mismatched++;
          $display("FAIL b2b_contiguous got bits=%h und=%b want bits=%h und=0", o.bits, o.und, stream(nxt, nxt ^ 16'h5A5A));
        end
        nxt = nxt + 16'd1;
      end
    end
    compared++; if (!seen) begin mismatched++; $display("FAIL b2b_data got no data frame want at least 1"); end
    compared++; if (viol != 0) begin mismatched++; $display("FAIL b2b_timing violations=%0d want 0", viol); end
    viol = 0;
  endtask

  task automatic test_load_coincide();
    logic [15:0] pl, pr;
    int unsigned budget, n0;
    obs_t        o;
    exp_t        x;
    pl     = 16'($urandom_range(1, 65535));
    pr     = 16'($urandom);
    budget = 4 * FRAME;
    while (!(m_full == 0 && load_edge(e + 1)) && budget > 0) begin
      cycle();
      budget--;
    end
    compared++; if (budget == 0) begin mismatched++; $display("FAIL coincide_timeout budget=0 want load edge"); end
    smp.left_in         = pl;
    smp.right_in        = pr;
    smp.sample_valid_in = 1'b1;
    cycle();
    smp.sample_valid_in = 1'b0;
    compared++; if (underrun_out !== 1'b1) begin mismatched++; $display("FAIL coincide_underrun got %b want 1", underrun_out); end
    compared++; if (smp.sample_ready_out !== 1'b0) begin mismatched++; $display("FAIL coincide_ready got %b want 0", smp.sample_ready_out); end
    n0 = obs_q.size();
    run_frames(n0 + 2);
    compared++;
    if (obs_q.size() < n0 + 2) begin
      mismatched++;
      $display("FAIL coincide_frames got %0d want %0d", obs_q.size(), n0 + 2);
    end else begin
      compared++;
      if (obs_q[n0].bits !== 64'h0 || obs_q[n0].und !== 1'b1) begin
        mismatched++;
        $display("FAIL coincide_zero_frame got bits=%h und=%b want bits=0 und=1", obs_q[n0].bits, obs_q[n0].und);
      end
      compared++;
      if (obs_q[n0 + 1].bits !== stream(pl, pr) || obs_q[n0 + 1].und !== 1'b0) begin
        mismatched++;
        $display("FAIL coincide_next_frame got bits=%h und=%b want bits=%h und=0", obs_q[n0 + 1].bits, obs_q[n0 + 1].und, stream(pl, pr));
      end
    end
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      o = obs_q.pop_front();
      x = exp_q.pop_front();
      compared++;
      if (o.bits !== stream(x.l, x.r) || o.und !== x.und || o.lr !== LR_EXP) begin
        mismatched++;
        $display("FAIL coincide_frame got bits=%h und=%b want bits=%h und=%b", o.bits, o.und, stream(x.l, x.r), x.und);
      end
    end
    compared++; if (viol != 0) begin mismatched++; $display("FAIL coincide_timing violations=%0d want 0", viol); end
    viol = 0;
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] al, ar, bl, br;
    int unsigned budget;
    obs_t        o;
    exp_t        x;
    al = 16'($urandom_range(1, 65535)); ar = 16'($urandom);
    bl = 16'($urandom_range(1, 65535)); br = 16'($urandom);
    budget = 3 * FRAME;
    while (m_full && budget > 0) begin cycle(); budget--; end
    smp.left_in = al; smp.right_in = ar; smp.sample_valid_in = 1'b1;
    cycle();
    smp.sample_valid_in = 1'b0;
    while (m_full && budget > 0) begin cycle(); budget--; end
    compared++; if (budget == 0) begin mismatched++; $display("FAIL rstmid_timeout budget=0 want load"); end
    smp.left_in = bl; smp.right_in = br; smp.sample_valid_in = 1'b1;
    cycle();
    smp.sample_valid_in = 1'b0;
    repeat (1500) cycle();
    compared++; if (lrcl_clk !== 1'b1) begin mismatched++; $display("FAIL rstmid_right_slot got lrcl=%b want 1", lrcl_clk); end
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      o = obs_q.pop_front();
      x = exp_q.pop_front();
      compared++;
      if (o.bits !== stream(x.l, x.r) || o.und !== x.und || o.lr !== LR_EXP) begin
        mismatched++;
        $display("FAIL rstmid_pre_frame got bits=%h und=%b want bits=%h und=%b", o.bits, o.und, stream(x.l, x.r), x.und);
      end
    end
    #3;
    rst_n = 1'b0;
    #1;
    compared++; if (i2s_clk !== 1'b0) begin mismatched++; $display("FAIL rstmid_i2s_clk got %b want 0", i2s_clk); end
    compared++; if (lrcl_clk !== 1'b0) begin mismatched++; $display("FAIL rstmid_lrcl got %b want 0", lrcl_clk); end
    compared++; if (sdata_out !== 1'b0) begin mismatched++; $display("FAIL rstmid_sdata got %b want 0", sdata_out); end
    compared++; if (smp.sample_ready_out !== 1'b1) begin mismatched++; $display("FAIL rstmid_ready got %b want 1", smp.sample_ready_out); end
    compared++; if (frame_start_out !== 1'b0 || underrun_out !== 1'b0) begin
      mismatched++; $display("FAIL rstmid_pulses got fs=%b und=%b want 0 0", frame_start_out, underrun_out);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    run_frames(2);
    compared++;
    if (obs_q.size() < 2) begin
      mismatched++;
      $display("FAIL rstmid_frames got %0d want 2", obs_q.size());
    end else begin
      compared++;
      if (obs_q[0].bits !== 64'h0 || obs_q[0].und !== 1'b1) begin
        mismatched++;
        $display("FAIL rstmid_underrun_frame got bits=%h und=%b want bits=0 und=1", obs_q[0].bits, obs_q[0].und);
      end
    end
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      o = obs_q.pop_front();
      x = exp_q.pop_front();
      compared++;
      if (o.bits[62:47] === al || o.bits[62:47] === bl) begin
        mismatched++;
        $display("FAIL rstmid_discarded got left=%h want neither %h nor %h", o.bits[62:47], al, bl);
      end
      compared++;
      if (o.bits !== stream(x.l, x.r) || o.und !== x.und || o.lr !== LR_EXP) begin
        mismatched++;
        $display("FAIL rstmid_frame got bits=%h und=%b want bits=%h und=%b", o.bits, o.und, stream(x.l, x.r), x.und);
      end
    end
    compared++; if (viol != 0) begin mismatched++; $display("FAIL rstmid_timing violations=%0d want 0", viol); end
    viol = 0;
  endtask

  task automatic test_random();
    int unsigned budget;
    obs_t        o;
    exp_t        x;
    budget = 8 * FRAME;
    while (obs_q.size() < 5 && budget > 0) begin
      smp.sample_valid_in = ($urandom_range(0, 1999) == 0);
      smp.left_in         = 16'($urandom);
      smp.right_in        = 16'($urandom);
      cycle();
      budget--;
    end
    smp.sample_valid_in = 1'b0;
    compared++; if (obs_q.size() < 5) begin mismatched++; $display("FAIL random_timeout frames=%0d want 5", obs_q.size()); end
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      o = obs_q.pop_front();
      x = exp_q.pop_front();
      compared++;
      if (o.bits !== stream(x.l, x.r) || o.und !== x.und || o.lr !== LR_EXP) begin
        mismatched++;
        $display("FAIL random_frame got bits=%h und=%b want bits=%h und=%b", o.bits, o.und, stream(x.l, x.r), x.und);
      end
    end
    compared++; if (viol != 0) begin mismatched++; $display("FAIL random_timing violations=%0d want 0", viol); end
    viol = 0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_patterns();
    test_back_to_back();
    test_load_coincide();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
